// File: rtl/dom1_skinny_pkg.sv
// Shared definitions for the masked SKINNY-128-384+ decrypt datapath:
// round count default, engine FSM encoding, state row slices and the inverse linear layer.
package dom1_skinny_pkg;

   localparam int NR_DEFAULT = 40;
   localparam int ROW_W      = 32;
   localparam int ROW0_LSB   = 96;
   localparam int ROW1_LSB   = 64;
   localparam int ROW2_LSB   = 32;
   localparam int ROW3_LSB   = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WKEY,
      ST_SB1,
      ST_SB2,
      ST_SB3,
      ST_SB4,
      ST_UPD,
      ST_DONE
   } state_e;

   // MC^-1 followed by SR^-1; linear, so it is applied to each share on its own
   function automatic logic [127:0] inv_lin(input logic [127:0] s);
      logic [ROW_W-1:0] m0, m1, m2, m3;
      logic [ROW_W-1:0] r0, r1, r2, r3;
      m0 = s[ROW0_LSB +: ROW_W];
      m1 = s[ROW1_LSB +: ROW_W];
      m2 = s[ROW2_LSB +: ROW_W];
      m3 = s[ROW3_LSB +: ROW_W];
      r0 = m1;
      r1 = m1 ^ m2 ^ m3;
      r2 = m1 ^ m3;
      r3 = m0 ^ m3;
      return {r0,
              {r1[23:0], r1[31:24]},
              {r2[15:0], r2[31:16]},
              {r3[7:0],  r3[31:8]}};
   endfunction

endpackage

// File: rtl/dom1_inv_sbox8.sv
// Masked inverse SKINNY S8 built from four layers of nor-xor gadgets,
// each layer clocked by its own bit of en.
module dom1_inv_sbox8 (
   input  logic       clk,
   input  logic [3:0] en,
   input  logic [7:0] o_s0,
   input  logic [7:0] o_s1,
   input  logic [7:0] r,
   output logic [7:0] b_s0,
   output logic [7:0] b_s1
);

   logic [1:0] o [8];
   logic [1:0] b0, b1, b2, b3, b4, b5, b6, b7;

   always_comb begin
      for (int k = 0; k < 8; k++) begin
         o[k] = {o_s1[k], o_s0[k]};
      end
   end

   dom1_sbox8_cfn_fr u_g0 (.clk(clk), .en(en[0]), .x(o[7]), .y(o[6]), .z(o[4]), .r(r[0]), .q(b3));
   dom1_sbox8_cfn_fr u_g1 (.clk(clk), .en(en[0]), .x(o[3]), .y(o[1]), .z(o[0]), .r(r[1]), .q(b2));
   dom1_sbox8_cfn_fr u_g2 (.clk(clk), .en(en[0]), .x(o[2]), .y(o[7]), .z(o[1]), .r(r[2]), .q(b7));
   dom1_sbox8_cfn_fr u_g3 (.clk(clk), .en(en[0]), .x(o[6]), .y(o[5]), .z(o[7]), .r(r[3]), .q(b5));
   dom1_sbox8_cfn_fr u_g4 (.clk(clk), .en(en[1]), .x(o[5]), .y(b3),   .z(o[3]), .r(r[4]), .q(b1));
   dom1_sbox8_cfn_fr u_g5 (.clk(clk), .en(en[1]), .x(b3),   .y(b2),   .z(o[5]), .r(r[5]), .q(b0));
   dom1_sbox8_cfn_fr u_g6 (.clk(clk), .en(en[2]), .x(b2),   .y(b1),   .z(o[2]), .r(r[6]), .q(b6));
   dom1_sbox8_cfn_fr u_g7 (.clk(clk), .en(en[3]), .x(b7),   .y(b6),   .z(o[6]), .r(r[7]), .q(b4));

   assign b_s0 = {b7[0], b6[0], b5[0], b4[0], b3[0], b2[0], b1[0], b0[0]};
   assign b_s1 = {b7[1], b6[1], b5[1], b4[1], b3[1], b2[1], b1[1], b0[1]};

endmodule

// File: rtl/dom1_sbox8_cfn_fr.sv
// First-order DOM gadget computing nor(x,y)^z on two shares; all four partial
// products are registered on en so no glitch can recombine the shares.
module dom1_sbox8_cfn_fr (
   input  logic       clk,
   input  logic       en,
   input  logic [1:0] x,
   input  logic [1:0] y,
   input  logic [1:0] z,
   input  logic       r,
   output logic [1:0] q
);

   logic inner0_d, inner0_q;
   logic cross0_d, cross0_q;
   logic inner1_d, inner1_q;
   logic cross1_d, cross1_q;

   // nor(x,y) = (~x0 ^ x1) & (~y0 ^ y1): the inversion is folded into share 0 only
   always_comb begin
      inner0_d = inner0_q;
      cross0_d = cross0_q;
      inner1_d = inner1_q;
      cross1_d = cross1_q;
      if (en) begin
         inner0_d = ((~x[0]) & (~y[0])) ^ z[0];
         cross0_d = ((~x[0]) & y[1]) ^ r;
         inner1_d = (x[1] & y[1]) ^ z[1];
         cross1_d = (x[1] & (~y[0])) ^ r;
      end
   end

   always_ff @(posedge clk) begin
      inner0_q <= inner0_d;
      cross0_q <= cross0_d;
      inner1_q <= inner1_d;
      cross1_q <= cross1_d;
   end

   assign q[0] = inner0_q ^ cross0_q;
   assign q[1] = inner1_q ^ cross1_q;

endmodule

// File: rtl/dom1_skinny_inv_rnd_engine.sv
// Two-share SKINNY-128-384+ inverse round engine: one inverse round per six-cycle pass,
// round tweakeys pulled from an external inverse key schedule.
module dom1_skinny_inv_rnd_engine
   import dom1_skinny_pkg::*;
#(
   parameter int NR = NR_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] ct0,
   input  logic [127:0] ct1,
   input  logic         in_vld,
   output logic         in_rdy,
   input  logic [127:0] rk0,
   input  logic [127:0] rk1,
   input  logic         rk_vld,
   output logic         rk_rdy,
   output logic [5:0]   rnd_idx,
   input  logic [127:0] r,
   output logic [127:0] pt0,
   output logic [127:0] pt1,
   output logic         out_vld,
   input  logic         out_rdy
);

   localparam logic [5:0] LAST_CNT = 6'(NR - 1);

   state_e       fsm_d, fsm_q;
   logic [5:0]   cnt_d, cnt_q;
   logic [127:0] st0_d, st0_q, st1_d, st1_q;
   logic [127:0] sbi0_d, sbi0_q, sbi1_d, sbi1_q;
   logic [127:0] sbo0, sbo1;
   logic [3:0]   en;

   always_comb begin
      fsm_d  = fsm_q;
      cnt_d  = cnt_q;
      st0_d  = st0_q;
      st1_d  = st1_q;
      sbi0_d = sbi0_q;
      sbi1_d = sbi1_q;
      en     = 4'b0000;
      case (fsm_q)
         ST_IDLE: begin
            if (in_vld) begin
               st0_d = ct0;
               st1_d = ct1;
               cnt_d = '0;
               fsm_d = ST_WKEY;
            end
         end
         ST_WKEY: begin
            if (rk_vld) begin
               sbi0_d = inv_lin(st0_q) ^ rk0;
               sbi1_d = inv_lin(st1_q) ^ rk1;
               fsm_d  = ST_SB1;
            end
         end
         ST_SB1: begin
            en    = 4'b0001;
            fsm_d = ST_SB2;
         end
         ST_SB2: begin
            en    = 4'b0010;
            fsm_d = ST_SB3;
         end
         ST_SB3: begin
            en    = 4'b0100;
            fsm_d = ST_SB4;
         end
         ST_SB4: begin
            en    = 4'b1000;
            fsm_d = ST_UPD;
         end
         ST_UPD: begin
            st0_d = sbo0;
            st1_d = sbo1;
            if (cnt_q == LAST_CNT) begin
               fsm_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + 6'd1;
               fsm_d = ST_WKEY;
            end
         end
         ST_DONE: begin
            if (out_rdy) begin
               fsm_d = ST_IDLE;
            end
         end
         default: fsm_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q  <= ST_IDLE;
         cnt_q  <= '0;
         st0_q  <= '0;
         st1_q  <= '0;
         sbi0_q <= '0;
         sbi1_q <= '0;
      end else begin
         fsm_q  <= fsm_d;
         cnt_q  <= cnt_d;
         st0_q  <= st0_d;
         st1_q  <= st1_d;
         sbi0_q <= sbi0_d;
         sbi1_q <= sbi1_d;
      end
   end

   // Byte j of r feeds S-box j; the S-box inputs stay frozen in sbi for all four layers
   for (genvar j = 0; j < 16; j++) begin : g_sbox
      dom1_inv_sbox8 u_sbox (
         .clk  (clk),
         .en   (en),
         .o_s0 (sbi0_q[8*j +: 8]),
         .o_s1 (sbi1_q[8*j +: 8]),
         .r    (r[8*j +: 8]),
         .b_s0 (sbo0[8*j +: 8]),
         .b_s1 (sbo1[8*j +: 8])
      );
   end

   assign in_rdy  = (fsm_q == ST_IDLE);
   assign rk_rdy  = (fsm_q == ST_WKEY);
   assign out_vld = (fsm_q == ST_DONE);
   assign rnd_idx = LAST_CNT - cnt_q;
   assign pt0     = st0_q;
   assign pt1     = st1_q;

endmodule

// File: tb/tb_dom1_skinny_inv_rnd_engine.sv
// Bench for the masked inverse round engine: random plaintexts are encrypted by an
// unmasked forward SKINNY model, then decrypted by the engine and compared.
module tb_dom1_skinny_inv_rnd_engine;

   localparam int NR = 40;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [127:0] ct0 = '0, ct1 = '0;
   logic         in_vld = 1'b0;
   logic         in_rdy;
   logic [127:0] rk0 = '0, rk1 = '0;
   logic         rk_vld = 1'b0;
   logic         rk_rdy;
   logic [5:0]   rnd_idx;
   logic [127:0] r = '0;
   logic [127:0] pt0, pt1;
   logic         out_vld;
   logic         out_rdy = 1'b0;

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0]   fwdTab [256];
   logic [127:0] rkTab  [NR];

   dom1_skinny_inv_rnd_engine #(.NR(NR)) dut (
      .clk     (clk),
      .rst     (rst),
      .ct0     (ct0),
      .ct1     (ct1),
      .in_vld  (in_vld),
      .in_rdy  (in_rdy),
      .rk0     (rk0),
      .rk1     (rk1),
      .rk_vld  (rk_vld),
      .rk_rdy  (rk_rdy),
      .rnd_idx (rnd_idx),
      .r       (r),
      .pt0     (pt0),
      .pt1     (pt1),
      .out_vld (out_vld),
      .out_rdy (out_rdy)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // The forward S-box is obtained by inverting the inverse S-box equations as a table
   task automatic buildTables();
      logic [7:0] o, b;
      for (int v = 0; v < 256; v++) begin
         o    = 8'(v);
         b[3] = ~(o[7] | o[6]) ^ o[4];
         b[2] = ~(o[3] | o[1]) ^ o[0];
         b[7] = ~(o[2] | o[7]) ^ o[1];
         b[5] = ~(o[6] | o[5]) ^ o[7];
         b[1] = ~(o[5] | b[3]) ^ o[3];
         b[0] = ~(b[3] | b[2]) ^ o[5];
         b[6] = ~(b[2] | b[1]) ^ o[2];
         b[4] = ~(b[7] | b[6]) ^ o[6];
         fwdTab[b] = o;
      end
   endtask

   // Forward round: SubCells, add round tweakey, ShiftRows (right by row), MixColumns
   function automatic logic [127:0] fwdRound(input logic [127:0] s, input logic [127:0] k);
      logic [127:0] t;
      logic [31:0]  m [4];
      logic [63:0]  dbl;
      for (int j = 0; j < 16; j++) t[8*j +: 8] = fwdTab[s[8*j +: 8]];
      t = t ^ k;
      for (int i = 0; i < 4; i++) begin
         dbl  = {t[96-32*i +: 32], t[96-32*i +: 32]};
         m[i] = dbl[8*i +: 32];
      end
      return {m[0] ^ m[2] ^ m[3], m[0], m[1] ^ m[2], m[0] ^ m[2]};
   endfunction

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_in_rdy"},  128'(in_rdy), 128'(1));
      checkOutput({tag, "_rk_rdy"},  128'(rk_rdy), 128'(0));
      checkOutput({tag, "_out_vld"}, 128'(out_vld), 128'(0));
      checkOutput({tag, "_pt0"},     pt0, 128'(0));
      checkOutput({tag, "_pt1"},     pt1, 128'(0));
      checkOutput({tag, "_rnd_idx"}, 128'(rnd_idx), 128'(NR - 1));
   endtask

   // One decryption; stallRound/pulseRound < 0 disable those disturbances, abortAt > 0
   // asserts reset that many clock edges after the input handshake
   task automatic applyStimulus(input int stallRound, input int outHold,
                                input int pulseRound, input int abortAt);
      logic [127:0] ptx, s, pt0Hold, pt1Hold;
      int           k, kround, stallCnt;
      bit           pulsed;
      ptx = rand128();
      for (int i = 0; i < NR; i++) rkTab[i] = rand128();
      s = ptx;
      for (int i = 0; i < NR; i++) s = fwdRound(s, rkTab[i]);
      @(negedge clk);
      checkOutput("in_rdy_idle", 128'(in_rdy), 128'(1));
      ct0    = rand128();
      ct1    = ct0 ^ s;
      in_vld = 1'b1;
      r      = rand128();
      @(negedge clk);
      in_vld = 1'b0;
      ct0    = rand128();
      ct1    = rand128();
      checkOutput("in_rdy_busy", 128'(in_rdy), 128'(0));
      k        = 1;
      kround   = 0;
      stallCnt = 0;
      pulsed   = 1'b0;
      while (!out_vld && k <= 400) begin
         if (abortAt > 0 && k - 1 == abortAt) begin
            rst    = 1'b1;
            in_vld = 1'b1;
            @(negedge clk);
            checkResetOutputs("abort");
            rst    = 1'b0;
            in_vld = 1'b0;
            @(negedge clk);
            checkOutput("rst_beats_in_vld", 128'(in_rdy), 128'(1));
            checkOutput("rst_no_rk_rdy", 128'(rk_rdy), 128'(0));
            return;
         end
         r      = rand128();
         in_vld = 1'b0;
         if (rk_rdy && kround < NR) begin
            if (kround == stallRound && stallCnt < 3) begin
               rk_vld = 1'b0;
               rk0    = rand128();
               rk1    = rand128();
               stallCnt++;
            end else begin
               rk_vld = 1'b1;
               rk0    = rand128();
               rk1    = rk0 ^ rkTab[NR - 1 - kround];
               checkOutput("rnd_idx", 128'(rnd_idx), 128'(NR - 1 - kround));
               kround++;
            end
         end else begin
            rk_vld = 1'b1;
            rk0    = rand128();
            rk1    = rand128();
         end
         if (pulseRound >= 0 && !pulsed && kround == pulseRound + 1 && !rk_rdy) begin
            in_vld = 1'b1;
            ct0    = rand128();
            ct1    = rand128();
            pulsed = 1'b1;
            checkOutput("in_rdy_pulse", 128'(in_rdy), 128'(0));
         end
         @(negedge clk);
         k++;
      end
      in_vld = 1'b0;
      checkOutput("out_vld_timeout", 128'(out_vld), 128'(1));
      if (!out_vld) return;
      checkOutput("latency", 128'(k - 1), 128'(6 * NR + (stallRound >= 0 ? 3 : 0)));
      checkOutput("keys_used", 128'(kround), 128'(NR));
      checkOutput("plaintext", pt0 ^ pt1, ptx);
      pt0Hold = pt0;
      pt1Hold = pt1;
      for (int h = 0; h < outHold; h++) begin
         r      = rand128();
         rk_vld = 1'b1;
         rk0    = rand128();
         rk1    = rand128();
         @(negedge clk);
         checkOutput("hold_out_vld", 128'(out_vld), 128'(1));
         checkOutput("hold_in_rdy", 128'(in_rdy), 128'(0));
         checkOutput("hold_pt0", pt0, pt0Hold);
         checkOutput("hold_pt1", pt1, pt1Hold);
      end
      out_rdy = 1'b1;
      @(negedge clk);
      out_rdy = 1'b0;
      checkOutput("out_vld_drop", 128'(out_vld), 128'(0));
      checkOutput("in_rdy_back", 128'(in_rdy), 128'(1));
   endtask

   initial begin
      buildTables();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checkResetOutputs("reset");
      rst = 1'b0;

      $display("[TB] plain decryption");
      applyStimulus(-1, 0, -1, 0);
      $display("[TB] in_vld pulse during round 3");
      applyStimulus(-1, 0, 3, 0);
      $display("[TB] reset in SB2 of round 7");
      applyStimulus(-1, 0, -1, 44);
      $display("[TB] fresh decryption after reset");
      applyStimulus(-1, 0, -1, 0);
      $display("[TB] key stall in round 5, output stall 10 cycles");
      applyStimulus(5, 10, -1, 0);
      $display("[TB] random decryptions");
      for (int t = 0; t < 6; t++) applyStimulus(-1, int'($urandom_range(0, 3)), -1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
